// File: rtl/audio_mixer_sd.sv
// Stereo audio back-end: time-multiplexed volume/enable mixer, one channel per slot,
// with a saturated per-frame mix feeding two first-order sigma-delta bitstream DACs.
module audio_mixer_sd #(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic             clkdac,
  input  logic             reset_n,
  input  logic [NCH*W-1:0] ch_sample,
  input  logic [NCH*4-1:0] ch_vol,
  input  logic [NCH-1:0]   ch_en_l,
  input  logic [NCH-1:0]   ch_en_r,
  input  logic             mute,
  output logic [W-1:0]     mix_l,
  output logic [W-1:0]     mix_r,
  output logic             frame_strb,
  output logic             audio_l,
  output logic             audio_r
);

  localparam int SW = $clog2(NCH);
  localparam int TW = W + 4;
  localparam int AW = TW + SW;
  localparam int LW = W + 2;
  localparam logic [SW-1:0] LAST    = SW'(NCH - 1);
  localparam logic [LW-1:0] SD_INIT = LW'(1) << W;

  // Index 0 is the left side, index 1 the right side.
  logic [SW-1:0] slot_q, slot_d;
  logic [AW-1:0] acc_q [2];
  logic [AW-1:0] acc_d [2];
  logic [W-1:0]  mix_q [2];
  logic [W-1:0]  mix_d [2];
  logic [LW-1:0] sd_q  [2];
  logic [LW-1:0] sd_d  [2];
  logic [1:0]    audio_q, audio_d;
  logic          strb_q, strb_d;

  logic [W-1:0]    smp;
  logic [3:0]      vol;
  logic [1:0]      en;
  logic [TW-1:0]   term;
  logic [AW-1:0]   sum    [2];
  logic [AW-5:0]   scaled [2];

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    smp = '0;
    vol = '0;
    en  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (slot_q == SW'(k)) begin
        smp = ch_sample[k*W +: W];
        vol = ch_vol[k*4 +: 4];
        en  = {ch_en_r[k], ch_en_l[k]};
      end
    end
    term = TW'(smp) * TW'(vol);
  end

  always_comb begin
    slot_d  = (slot_q == LAST) ? '0 : slot_q + 1'b1;
    strb_d  = (slot_q == LAST);
    audio_d = '0;
    for (int s = 0; s < 2; s++) begin
      // Slot 0 starts a fresh sum from the term alone, so no clear cycle is needed.
      sum[s]    = ((slot_q == '0) ? AW'(0) : acc_q[s]) + (en[s] ? AW'(term) : AW'(0));
      acc_d[s]  = sum[s];
      scaled[s] = sum[s][AW-1:4];
      mix_d[s]  = mix_q[s];
      if (strb_d) begin
        if (mute)                    mix_d[s] = '0;
        else if (|scaled[s][AW-5:W]) mix_d[s] = '1;
        else                         mix_d[s] = scaled[s][W-1:0];
      end
      // Feedback subtracts 2^W whenever the latch MSB is set (two's-complement add of {1,1}<<W).
      sd_d[s]    = sd_q[s] + LW'(mix_q[s]) + {sd_q[s][LW-1], sd_q[s][LW-1], W'(0)};
      audio_d[s] = sd_q[s][LW-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clkdac or negedge reset_n) begin
    if (!reset_n) begin
      slot_q  <= '0;
      strb_q  <= 1'b0;
      audio_q <= '0;
      for (int s = 0; s < 2; s++) begin
        acc_q[s] <= '0;
        mix_q[s] <= '0;
        sd_q[s]  <= SD_INIT;
      end
    end else begin
      slot_q  <= slot_d;
      strb_q  <= strb_d;
      audio_q <= audio_d;
      for (int s = 0; s < 2; s++) begin
        acc_q[s] <= acc_d[s];
        mix_q[s] <= mix_d[s];
        sd_q[s]  <= sd_d[s];
      end
    end
  end

  assign mix_l      = mix_q[0];
  assign mix_r      = mix_q[1];
  assign frame_strb = strb_q;
  assign audio_l    = audio_q[0];
  assign audio_r    = audio_q[1];

endmodule

// File: tb/tb_audio_mixer_sd.sv
// Scoreboard bench for audio_mixer_sd: frames are issued with expected mixes queued from an
// arithmetic reference; a monitor pops and compares on every frame_strb.
module tb_audio_mixer_sd;

  localparam int NCH  = 4;
  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;
  localparam int MEAS_FRAMES = (1 << W) / NCH;

  logic             clkdac = 1'b0;
  logic             reset_n = 1'b1;
  logic [NCH*W-1:0] ch_sample = '0;
  logic [NCH*4-1:0] ch_vol = '0;
  logic [NCH-1:0]   ch_en_l = '0;
  logic [NCH-1:0]   ch_en_r = '0;
  logic             mute = 1'b0;
  logic [W-1:0]     mix_l, mix_r;
  logic             frame_strb, audio_l, audio_r;

  always #5 clkdac = ~clkdac;

  audio_mixer_sd #(.NCH(NCH), .W(W)) dut (
    .clkdac     (clkdac),
    .reset_n    (reset_n),
    .ch_sample  (ch_sample),
    .ch_vol     (ch_vol),
    .ch_en_l    (ch_en_l),
    .ch_en_r    (ch_en_r),
    .mute       (mute),
    .mix_l      (mix_l),
    .mix_r      (mix_r),
    .frame_strb (frame_strb),
    .audio_l    (audio_l),
    .audio_r    (audio_r)
  );

  typedef struct {
    int smp [NCH];
    int vol [NCH];
    int en_l;
    int en_r;
    int mute;
  } frame_t;

  typedef struct {
    int l;
    int r;
  } exp_t;

  exp_t exp_q [$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edges    = 0;
  int   prev_l   = 0;
  int   prev_r   = 0;
  int   ones_l   = 0;
  int   ones_r   = 0;
  bit   cnt_en   = 1'b0;

  task automatic check(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  function automatic frame_t uni(input int s, input int v, input int el, input int er, input int m);
    frame_t f;
    for (int k = 0; k < NCH; k++) begin
      f.smp[k] = s;
      f.vol[k] = v;
    end
    f.en_l = el;
    f.en_r = er;
    f.mute = m;
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int k = 0; k < NCH; k++) begin
      f.smp[k] = int'($urandom_range(0, MAXV));
      f.vol[k] = int'($urandom_range(0, 15));
    end
    f.en_l = int'($urandom_range(0, (1 << NCH) - 1));
    f.en_r = int'($urandom_range(0, (1 << NCH) - 1));
    f.mute = ($urandom_range(0, 7) == 0) ? 1 : 0;
    return f;
  endfunction

  // Reference: weighted sum of enabled channels, /16, clamped; each channel (and mute, read at
  // the last slot) comes from whichever input set is present during its own slot.
  function automatic exp_t ref_mix(input frame_t a, input frame_t b, input int late_after);
    exp_t   e;
    frame_t f;
    int     sl = 0;
    int     sr = 0;
    int     m  = 0;
    for (int k = 0; k < NCH; k++) begin
      if (late_after >= 0 && k > late_after) f = b;
      else                                   f = a;
      if (((f.en_l >> k) & 1) == 1) sl += f.smp[k] * f.vol[k];
      if (((f.en_r >> k) & 1) == 1) sr += f.smp[k] * f.vol[k];
      if (k == NCH - 1) m = f.mute;
    end
    e.l = (m != 0) ? 0 : ((sl / 16 > MAXV) ? MAXV : sl / 16);
    e.r = (m != 0) ? 0 : ((sr / 16 > MAXV) ? MAXV : sr / 16);
    return e;
  endfunction

  task automatic apply(input frame_t f);
    for (int k = 0; k < NCH; k++) begin
      ch_sample[k*W +: W] = W'(f.smp[k]);
      ch_vol[k*4 +: 4]    = 4'(f.vol[k]);
    end
    ch_en_l = NCH'(f.en_l);
    ch_en_r = NCH'(f.en_r);
    mute    = (f.mute != 0);
  endtask

  // Called at the negedge just before a slot-0 edge; returns at the negedge after the strobe edge.
  task automatic run_frame(input frame_t a, input frame_t b, input int late_after);
    exp_t e;
    apply(a);
    e = ref_mix(a, b, late_after);
    exp_q.push_back(e);
    for (int c = 0; c < NCH; c++) begin
      @(negedge clkdac);
      if (cnt_en) begin
        ones_l += int'(audio_l);
        ones_r += int'(audio_r);
      end
      if (c < NCH - 1) begin
        check("mix_hold_l", int'(mix_l), prev_l, prev_l);
        check("mix_hold_r", int'(mix_r), prev_r, prev_r);
      end
      if (c == late_after) apply(b);
    end
    prev_l = e.l;
    prev_r = e.r;
  endtask

  task automatic run_same(input frame_t f, input int n);
    for (int i = 0; i < n; i++) run_frame(f, f, -1);
  endtask

  // Duty over 2^W cycles must equal mix within one count, never 2^W ones, and exactly 0 for mix 0.
  task automatic measure(input string name, input frame_t f);
    exp_t e;
    int   lo_l, hi_l, lo_r, hi_r;
    e = ref_mix(f, f, -1);
    run_same(f, 2);
    ones_l = 0;
    ones_r = 0;
    cnt_en = 1'b1;
    run_same(f, MEAS_FRAMES);
    cnt_en = 1'b0;
    lo_l = (e.l > 0) ? e.l - 1 : 0;
    hi_l = (e.l == 0) ? 0 : ((e.l == MAXV) ? MAXV : e.l + 1);
    lo_r = (e.r > 0) ? e.r - 1 : 0;
    hi_r = (e.r == 0) ? 0 : ((e.r == MAXV) ? MAXV : e.r + 1);
    check({name, "_duty_l"}, ones_l, lo_l, hi_l);
    check({name, "_duty_r"}, ones_r, lo_r, hi_r);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_mix_l"}, int'(mix_l), 0, 0);
    check({name, "_mix_r"}, int'(mix_r), 0, 0);
    check({name, "_strb"}, int'(frame_strb), 0, 0);
    check({name, "_audio_l"}, int'(audio_l), 0, 0);
    check({name, "_audio_r"}, int'(audio_r), 0, 0);
  endtask

  always @(posedge clkdac or negedge reset_n) begin
    if (!reset_n) edges <= 0;
    else          edges <= edges + 1;
  end

  // Monitor: strobe cadence from the bench's own edge count, mix values from the scoreboard.
  always @(negedge clkdac) begin
    if (reset_n) begin
      check("strb_timing", int'(frame_strb),
            (edges > 0 && edges % NCH == 0) ? 1 : 0, (edges > 0 && edges % NCH == 0) ? 1 : 0);
      if (frame_strb) begin
        if (exp_q.size() == 0) begin
          check("strb_unexpected", 1, 0, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("mix_l", int'(mix_l), mon_e.l, mon_e.l);
          check("mix_r", int'(mix_r), mon_e.r, mon_e.r);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, expected end before %0t", $time);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    frame_t loud, f, g;

    loud = uni(MAXV, 15, (1 << NCH) - 1, (1 << NCH) - 1, 0);
    apply(uni(MAXV, 15, (1 << NCH) - 1, (1 << NCH) - 1, 1));
    #1 reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clkdac);
      check_outputs_zero("reset");
    end
    @(posedge clkdac);
    #2 reset_n = 1'b1;
    @(negedge clkdac);

    // Saturation: 4*255*15/16 = 956 clamps to 255 on both sides.
    run_frame(loud, loud, -1);
    measure("sat", loud);

    // Single channel: 200*15/16 = 187 on the left only.
    f = uni(0, 0, 1, 0, 0);
    f.smp[0] = 200;
    f.vol[0] = 15;
    measure("single", f);

    // Mute raised mid-frame takes effect at this frame's boundary; then right side masked off.
    run_same(loud, 2);
    g = loud;
    g.mute = 1;
    run_frame(loud, g, 1);
    measure("mute", g);
    g = loud;
    g.en_r = 0;
    measure("recover", g);

    // Slot sampling: ch2 changes just after its slot, so it shows only in the next frame (80).
    f = uni(0, 8, (1 << NCH) - 1, 0, 0);
    g = f;
    g.smp[2] = 160;
    run_frame(f, g, 2);
    run_frame(g, g, -1);

    // Short reset pulse at slot 2 of a loud frame; the following frame must be clean.
    run_same(loud, 2);
    apply(loud);
    @(negedge clkdac);
    @(negedge clkdac);
    @(posedge clkdac);
    #1 reset_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    #1 reset_n = 1'b1;
    prev_l = 0;
    prev_r = 0;
    @(negedge clkdac);
    f = uni(0, 3, (1 << NCH) - 1, 5, 0);
    f.smp[0] = 10;
    f.smp[1] = 20;
    f.smp[2] = 30;
    f.smp[3] = 40;
    run_frame(f, f, -1);

    // Randomized frames, some with inputs changing mid-frame.
    for (int i = 0; i < 40; i++) begin
      f = rand_frame();
      g = rand_frame();
      run_frame(f, g, int'($urandom_range(0, NCH)) - 1);
    end

    @(negedge clkdac);
    check("queue_drain", exp_q.size(), 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
